// File: rtl/s2p_symbol_mapper.sv
// Serial-to-parallel symbol grouper for the PSK/QAM mappers. It samples one bit per
// bit period, packs BPS bits into a symbol and strobes each completed symbol for one clock.
module s2p_symbol_mapper #(
  parameter int BPS          = 2,
  parameter int BIT_PERIOD   = 10,
  parameter int SAMPLE_PHASE = 0,
  parameter int CNT_W        = 8,
  localparam int IDX_W       = (BPS > 1) ? $clog2(BPS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             msb_first,
  input  logic             data_in,
  output logic [BPS-1:0]   sym_out,
  output logic             sym_valid,
  output logic [IDX_W-1:0] bit_idx
);

  localparam logic [CNT_W-1:0] BCNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] BCNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] BCNT_LAST   = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] BCNT_SAMPLE = CNT_W'(SAMPLE_PHASE);
  localparam logic [IDX_W-1:0] IDX_ZERO    = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(BPS - 1);
  localparam logic [BPS-1:0]   SR_ZERO     = {BPS{1'b0}};

  logic [CNT_W-1:0] bcnt_r, bcnt_nxt_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  logic [BPS-1:0]   sr_r, sr_nxt_s;
  logic [BPS-1:0]   sym_out_r, sym_nxt_s;
  logic             mode_r, mode_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic             mode_eff_s;
  logic [BPS-1:0]   shifted_s;

  // Next-state: sync beats en; bit order is latched on the first bit of each symbol.
  always_comb begin
    bcnt_nxt_s  = bcnt_r;
    idx_nxt_s   = idx_r;
    sr_nxt_s    = sr_r;
    mode_nxt_s  = mode_r;
    sym_nxt_s   = sym_out_r;
    valid_nxt_s = 1'b0;
    mode_eff_s  = mode_r;
    shifted_s   = sr_r;
    if (sync) begin
      bcnt_nxt_s = BCNT_ZERO;
      idx_nxt_s  = IDX_ZERO;
      sr_nxt_s   = SR_ZERO;
    end else if (en) begin
      if (bcnt_r == BCNT_LAST) begin
        bcnt_nxt_s = BCNT_ZERO;
      end else begin
        bcnt_nxt_s = bcnt_r + BCNT_ONE;
      end
      if (bcnt_r == BCNT_SAMPLE) begin
        mode_eff_s = (idx_r == IDX_ZERO) ? msb_first : mode_r;
        mode_nxt_s = mode_eff_s;
        shifted_s  = mode_eff_s ? {sr_r[BPS-2:0], data_in} : {data_in, sr_r[BPS-1:1]};
        sr_nxt_s   = shifted_s;
        // Explicit compare keeps non-power-of-two BPS legal.
        if (idx_r == IDX_LAST) begin
          idx_nxt_s   = IDX_ZERO;
          sym_nxt_s   = shifted_s;
          valid_nxt_s = 1'b1;
        end else begin
          idx_nxt_s   = idx_r + IDX_ONE;
        end
      end else begin
        sr_nxt_s = sr_r;
      end
    end else begin
      valid_nxt_s = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_r    <= BCNT_ZERO;
      idx_r     <= IDX_ZERO;
      sr_r      <= SR_ZERO;
      mode_r    <= 1'b1;
      sym_out_r <= SR_ZERO;
      valid_r   <= 1'b0;
    end else begin
      bcnt_r    <= bcnt_nxt_s;
      idx_r     <= idx_nxt_s;
      sr_r      <= sr_nxt_s;
      mode_r    <= mode_nxt_s;
      sym_out_r <= sym_nxt_s;
      valid_r   <= valid_nxt_s;
    end
  end

  assign sym_out   = sym_out_r;
  assign sym_valid = valid_r;
  assign bit_idx   = idx_r;

endmodule

// File: tb/tb_s2p_symbol_mapper.sv
// Directed bench for s2p_symbol_mapper: a default QPSK instance and a BPS=3 instance
// share the stimulus; expected values are hand-derived per cycle.
module tb_s2p_symbol_mapper;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sync;
  logic       msb_first;
  logic       data_in;
  logic [1:0] sym_a;
  logic       valid_a;
  logic [0:0] idx_a;
  logic [2:0] sym_b;
  logic       valid_b;
  logic [1:0] idx_b;

  int checks;
  int failures;
  int bits3 [9] = '{1, 1, 0, 0, 1, 1, 1, 0, 1};

  s2p_symbol_mapper dut_a (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .msb_first(msb_first),
    .data_in(data_in), .sym_out(sym_a), .sym_valid(valid_a), .bit_idx(idx_a)
  );

  s2p_symbol_mapper #(.BPS(3), .BIT_PERIOD(4), .SAMPLE_PHASE(2), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .msb_first(msb_first),
    .data_in(data_in), .sym_out(sym_b), .sym_valid(valid_b), .bit_idx(idx_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic d);
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse checked between edges; leaves the DUTs released.
  task automatic do_reset(input string tag);
    rst  = 1'b0;
    en   = 1'b0;
    sync = 1'b0;
    #2;
    check_eq({tag, " rst sym_a"}, 32'(sym_a), 32'd0);
    check_eq({tag, " rst valid_a"}, 32'(valid_a), 32'd0);
    check_eq({tag, " rst idx_a"}, 32'(idx_a), 32'd0);
    check_eq({tag, " rst sym_b"}, 32'(sym_b), 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    en        = 1'b0;
    sync      = 1'b0;
    msb_first = 1'b1;
    data_in   = 1'b0;
    #6;
    do_reset("init");

    // MSB-first QPSK, two symbols 10 then 01
    for (int c = 0; c < 40; c++) begin
      en = 1'b1; msb_first = 1'b1;
      step((c < 10) || (c >= 30));
      check_eq($sformatf("t1 valid c%0d", c), 32'(valid_a), 32'((c == 10) || (c == 30)));
      check_eq($sformatf("t1 sym c%0d", c), 32'(sym_a), (c < 10) ? 32'd0 : (c < 30) ? 32'd2 : 32'd1);
      check_eq($sformatf("t1 idx c%0d", c), 32'(idx_a), 32'(((c / 10) % 2) == 0));
    end

    // LSB-first first symbol; msb_first toggled mid-symbol is ignored
    do_reset("t2");
    for (int c = 0; c < 40; c++) begin
      en = 1'b1; msb_first = (c >= 5);
      step((c < 10) || (c >= 30));
      check_eq($sformatf("t2 valid c%0d", c), 32'(valid_a), 32'((c == 10) || (c == 30)));
      check_eq($sformatf("t2 sym c%0d", c), 32'(sym_a), (c < 10) ? 32'd0 : 32'd1);
    end

    // BPS=3 instance: symbols 110, 011, 101 every 12 clocks
    do_reset("t3");
    for (int c = 0; c < 36; c++) begin
      en = 1'b1; msb_first = 1'b1;
      step(bits3[c / 4] != 0);
      check_eq($sformatf("t3 valid c%0d", c), 32'(valid_b), 32'((c == 10) || (c == 22) || (c == 34)));
      check_eq($sformatf("t3 sym c%0d", c), 32'(sym_b),
               (c < 10) ? 32'd0 : (c < 22) ? 32'd6 : (c < 34) ? 32'd3 : 32'd5);
      check_eq($sformatf("t3 idx c%0d", c), 32'(idx_b), 32'(((c + 2) / 4) % 3));
    end

    // en low for 7 edges mid-symbol delays completion by 7 clocks
    do_reset("t4");
    for (int c = 0; c < 26; c++) begin
      en = !((c >= 3) && (c <= 9)); msb_first = 1'b1;
      step(c < 17);
      check_eq($sformatf("t4 valid c%0d", c), 32'(valid_a), 32'(c == 17));
      check_eq($sformatf("t4 sym c%0d", c), 32'(sym_a), (c < 17) ? 32'd0 : 32'd2);
      check_eq($sformatf("t4 idx c%0d", c), 32'(idx_a), 32'(c < 17));
    end

    // sync after one bit discards it; old symbol holds until the realigned strobe
    do_reset("t5");
    for (int c = 0; c < 40; c++) begin
      en = 1'b1; msb_first = 1'b1; sync = (c == 25);
      step((c < 20) || (c >= 36));
      check_eq($sformatf("t5 valid c%0d", c), 32'(valid_a), 32'((c == 10) || (c == 36)));
      check_eq($sformatf("t5 sym c%0d", c), 32'(sym_a), (c < 10) ? 32'd0 : (c < 36) ? 32'd3 : 32'd1);
      check_eq($sformatf("t5 idx c%0d", c), 32'(idx_a),
               32'(((c < 10) || ((c >= 20) && (c < 25)) || ((c >= 26) && (c < 36)))));
    end
    sync = 1'b0;

    // asynchronous reset mid-symbol with sym_out=11; no strobe after release
    do_reset("t6pre");
    for (int c = 0; c < 21; c++) begin
      en = 1'b1; msb_first = 1'b1;
      step(1'b1);
      check_eq($sformatf("t6 valid c%0d", c), 32'(valid_a), 32'(c == 10));
    end
    check_eq("t6 pre sym", 32'(sym_a), 32'd3);
    check_eq("t6 pre idx", 32'(idx_a), 32'd1);
    do_reset("t6");
    for (int c = 0; c < 9; c++) begin
      en = 1'b1; msb_first = 1'b1;
      step(1'b0);
      check_eq($sformatf("t6 post valid c%0d", c), 32'(valid_a), 32'd0);
      check_eq($sformatf("t6 post sym c%0d", c), 32'(sym_a), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
